// File: rtl/risc_mem_pkg.sv
// Shared types for the memory arbiter: FSM states, access owner encoding and default bus widths.
package risc_mem_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int CNT_W      = 2;  // wide enough for MEM_LAT-1 with MEM_LAT up to 4

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;
endpackage

// File: rtl/mem_lat_counter.sv
// Memory latency down-counter: loads a start value, decrements on request, flags zero.
// Single-cycle update; no backpressure (the FSM decides when to load and decrement).
module mem_lat_counter
  import risc_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - CNT_W'(1);
  end

  assign zero = (count == '0);
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one memory port; MEM_ARB_RR_EN selects round-robin.
// Done pulses MEM_LAT+2 cycles after the request is sampled in IDLE; requesters simply hold req until granted.
module mem_arbiter
  import risc_mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              if_done,
  output logic              ls_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  state_t            state, state_nxt;
  owner_t            owner;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic              take, grant_ls;
  logic              cnt_load, cnt_dec, cnt_zero, finish;

  assign take = (state == IDLE) && (if_req || ls_req);

`ifdef MEM_ARB_RR_EN
  logic rr_ptr;  // 1 = fetch wins the next tie

  assign grant_ls = ls_req && (!if_req || !rr_ptr);

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= 1'b0;
    else if (take)
      rr_ptr <= grant_ls;
  end
`else
  assign grant_ls = ls_req;
`endif

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE:  if (take) state_nxt = ISSUE;
      ISSUE: begin
        cnt_load  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt_zero) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      rdata     <= '0;
      if_done   <= 1'b0;
      ls_done   <= 1'b0;
    end else begin
      state   <= state_nxt;
      if_done <= finish && (owner == OWN_IF);
      ls_done <= finish && (owner == OWN_LS);
      if (finish && !lat_we)
        rdata <= mem_rdata;
      // Requester inputs are captured once here and ignored for the rest of the access.
      if (take) begin
        owner     <= grant_ls ? OWN_LS : OWN_IF;
        lat_addr  <= grant_ls ? ls_addr : if_addr;
        lat_we    <= grant_ls && ls_we;
        lat_wdata <= grant_ls ? ls_wdata : '0;
      end
    end
  end

  mem_lat_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(MEM_LAT - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en && lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one MEM_LAT=1 and one MEM_LAT=4 instance sharing requester stimulus.
module tb_mem_arbiter;
  import risc_mem_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [AW-1:0] if_addr = '0, ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;

  logic          if_done1, ls_done1, busy1, men1, mwe1;
  logic [AW-1:0] maddr1;
  logic [DW-1:0] mwd1, mrd1, rdata1;
  logic          if_done4, ls_done4, busy4, men4, mwe4;
  logic [AW-1:0] maddr4;
  logic [DW-1:0] mwd4, mrd4, rdata4;

  logic [DW-1:0] mem [0:65535];
  bit            wrv [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  logic [DW-1:0] p1;
  logic [DW-1:0] p4 [0:3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .ls_req(ls_req), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .if_done(if_done1), .ls_done(ls_done1), .rdata(rdata1),
    .mem_en(men1), .mem_we(mwe1), .mem_addr(maddr1), .mem_wdata(mwd1), .mem_rdata(mrd1), .busy(busy1)
  );

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .ls_req(ls_req), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .if_done(if_done4), .ls_done(ls_done4), .rdata(rdata4),
    .mem_en(men4), .mem_we(mwe4), .mem_addr(maddr4), .mem_wdata(mwd4), .mem_rdata(mrd4), .busy(busy4)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 16'h0010) return 16'hA5A5;
    return (a * 16'd73) ^ 16'h5C3E;
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return wrv[a] ? mem[a] : init_val(a);
  endfunction

  // Memory: the MEM_LAT=1 instance owns writes; the MEM_LAT=4 instance only reads.
  always @(posedge clk) begin
    if (men1 && mwe1) begin
      mem[maddr1] <= mwd1;
      wrv[maddr1] <= 1'b1;
    end
    p1    <= mem_rd(maddr1);
    p4[0] <= mem_rd(maddr4);
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign mrd1 = p1;
  assign mrd4 = p4[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    tick(); tick();
    n_chk++;
    if ({men1, mwe1, if_done1, ls_done1, busy1} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl1: got en/we/ifd/lsd/busy=%b want 00000", {men1, mwe1, if_done1, ls_done1, busy1});
    end
    n_chk++;
    if ({maddr1, mwd1, rdata1} !== 48'h0) begin
      n_fail++; $display("FAIL reset_bus1: got addr=%h wdata=%h rdata=%h want zeros", maddr1, mwd1, rdata1);
    end
    n_chk++;
    if ({men4, busy4, if_done4, ls_done4, rdata4} !== 20'h0) begin
      n_fail++; $display("FAIL reset_dut4: got en=%b busy=%b rdata=%h want zeros", men4, busy4, rdata4);
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if (busy1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b want 0 with no request", busy1);
    end
  endtask

  task automatic test_fetch();
    apply_reset();
    if_req = 1'b1; if_addr = 16'h0010;
    tick();
    if_req = 1'b0;
    n_chk++;
    if ({men1, mwe1, busy1} !== 3'b101 || maddr1 !== 16'h0010) begin
      n_fail++; $display("FAIL fetch_issue: en/we/busy=%b addr=%h want 101 addr=0010", {men1, mwe1, busy1}, maddr1);
    end
    tick();
    n_chk++;
    if ({men1, if_done1} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_c2: en/done=%b want 00", {men1, if_done1});
    end
    tick();
    n_chk++;
    if (if_done1 !== 1'b1 || ls_done1 !== 1'b0 || rdata1 !== 16'hA5A5) begin
      n_fail++; $display("FAIL fetch_done: if_done=%b ls_done=%b rdata=%h want 1 0 a5a5", if_done1, ls_done1, rdata1);
    end
    tick();
    n_chk++;
    if (if_done1 !== 1'b0) begin
      n_fail++; $display("FAIL fetch_pulse: if_done=%b want 0 one cycle after done", if_done1);
    end
  endtask

  task automatic test_store();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0200; ls_wdata = 16'h1234;
    tick();
    ls_req = 1'b0; ls_we = 1'b0;
    n_chk++;
    if ({men1, mwe1} !== 2'b11 || maddr1 !== 16'h0200 || mwd1 !== 16'h1234) begin
      n_fail++; $display("FAIL store_issue: en/we=%b addr=%h wdata=%h want 11 0200 1234", {men1, mwe1}, maddr1, mwd1);
    end
    tick(); tick();
    n_chk++;
    if (ls_done1 !== 1'b1 || if_done1 !== 1'b0) begin
      n_fail++; $display("FAIL store_done: ls_done=%b if_done=%b want 1 0 at cycle 3", ls_done1, if_done1);
    end
    n_chk++;
    if (rdata1 !== 16'hA5A5) begin
      n_fail++; $display("FAIL store_rdata: rdata=%h want a5a5 (unchanged by write)", rdata1);
    end
    n_chk++;
    if (mem_rd(16'h0200) !== 16'h1234) begin
      n_fail++; $display("FAIL store_mem: mem[0200]=%h want 1234", mem_rd(16'h0200));
    end
  endtask

  task automatic test_conflict();
    int  got, c;
    logic exp_ls;
    apply_reset();
    if_req = 1'b1; if_addr = 16'h0005; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0006;
    got = 0; c = 0;
    while (got < 4 && c < 40) begin
      tick(); c++;
      n_chk++;
      if (if_done1 && ls_done1) begin
        n_fail++; $display("FAIL conflict_excl: both dones high at cycle %0d", c);
      end
      if (if_done1 || ls_done1) begin
`ifdef MEM_ARB_RR_EN
        exp_ls = (got % 2 == 0);
`else
        exp_ls = 1'b1;
`endif
        n_chk++;
        if (ls_done1 !== exp_ls || c != 3 * (got + 1)) begin
          n_fail++; $display("FAIL conflict_grant%0d: ls_done=%b cycle=%0d want %b cycle %0d", got, ls_done1, c, exp_ls, 3 * (got + 1));
        end
        n_chk++;
        if (rdata1 !== mem_rd(exp_ls ? 16'h0006 : 16'h0005)) begin
          n_fail++; $display("FAIL conflict_rdata%0d: rdata=%h want %h", got, rdata1, mem_rd(exp_ls ? 16'h0006 : 16'h0005));
        end
        got++;
      end
    end
    n_chk++;
    if (got != 4) begin
      n_fail++; $display("FAIL conflict_timeout: %0d grants seen want 4", got);
    end
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  task automatic test_mem_lat4();
    int en_cnt, done_at, first_en;
    logic [AW-1:0] a;
    logic [DW-1:0] rd;
    apply_reset();
    a = 16'($urandom_range(0, 31));
    if_req = 1'b1; if_addr = a;
    tick();
    if_req = 1'b0;
    en_cnt = 0; done_at = -1; first_en = -1; rd = '0;
    for (int c = 1; c <= 12; c++) begin
      if (men4) begin
        en_cnt++;
        if (first_en < 0) first_en = c;
      end
      if (if_done4 && done_at < 0) begin
        done_at = c; rd = rdata4;
      end
      tick();
    end
    n_chk++;
    if (done_at != 6) begin
      n_fail++; $display("FAIL lat4_latency: done at cycle %0d want 6", done_at);
    end
    n_chk++;
    if (en_cnt != 1 || first_en != 1) begin
      n_fail++; $display("FAIL lat4_en: mem_en high %0d cycles first at %0d want 1 at 1", en_cnt, first_en);
    end
    n_chk++;
    if (rd !== mem_rd(a)) begin
      n_fail++; $display("FAIL lat4_rdata: rdata=%h want %h", rd, mem_rd(a));
    end
  endtask

  task automatic test_reset_wait();
    apply_reset();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0010;
    tick();
    ls_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_chk++;
    if ({ls_done1, busy1, men1, busy4, ls_done4} !== 5'b0) begin
      n_fail++; $display("FAIL rstwait_abort: ls_done/busy/en/busy4/ls_done4=%b want 00000", {ls_done1, busy1, men1, busy4, ls_done4});
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_chk++;
      if (if_done1 || ls_done1 || if_done4 || ls_done4) begin
        n_fail++; $display("FAIL rstwait_nodone: done pulse %0d cycles after reset", c + 1);
      end
    end
    if_req = 1'b1; if_addr = 16'h0010;
    tick();
    if_req = 1'b0;
    tick(); tick();
    n_chk++;
    if (if_done1 !== 1'b1 || rdata1 !== 16'hA5A5) begin
      n_fail++; $display("FAIL rstwait_fresh: if_done=%b rdata=%h want 1 a5a5", if_done1, rdata1);
    end
  endtask

  task automatic test_dropped();
    int pulses, first;
    apply_reset();
    if_req = 1'b1; if_addr = 16'h0011;
    tick();
    if_req = 1'b0;
    pulses = 0; first = -1;
    for (int c = 1; c <= 10; c++) begin
      if (if_done1) begin
        pulses++;
        if (first < 0) first = c;
      end
      tick();
    end
    n_chk++;
    if (pulses != 1 || first != 3) begin
      n_fail++; $display("FAIL dropped_done: %0d pulses first at %0d want 1 at 3", pulses, first);
    end
    n_chk++;
    if (rdata1 !== mem_rd(16'h0011)) begin
      n_fail++; $display("FAIL dropped_rdata: rdata=%h want %h", rdata1, mem_rd(16'h0011));
    end
  endtask

  // Reference model: one access in flight, granted when the arbiter is free, done 3 cycles later.
  task automatic test_random();
    bit pend, own_ls, rd, win_ls, exp_we;
    bit e_if, e_ls, e_en, e_busy;
    int grant_c, done_c;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd, exp_data, model_rdata;
`ifdef MEM_ARB_RR_EN
    bit ptr;
    ptr = 1'b0;
`endif
    pend = 0; own_ls = 0; rd = 0; exp_we = 0; grant_c = -10; done_c = -10;
    exp_addr = '0; exp_wd = '0; exp_data = '0; model_rdata = '0;
    apply_reset();
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem_rd(16'(i));
    for (int k = 0; k < 600; k++) begin
      if (pend && k == done_c && rd) model_rdata = exp_data;
      e_if   = pend && k == done_c && !own_ls;
      e_ls   = pend && k == done_c && own_ls;
      e_en   = pend && k == grant_c + 1;
      e_busy = pend && k > grant_c && k < done_c;
      n_chk++;
      if ({if_done1, ls_done1, men1, busy1} !== {e_if, e_ls, e_en, e_busy}) begin
        n_fail++; $display("FAIL rand_ctl c%0d: ifd/lsd/en/busy=%b want %b", k, {if_done1, ls_done1, men1, busy1}, {e_if, e_ls, e_en, e_busy});
      end
      n_chk++;
      if (rdata1 !== model_rdata) begin
        n_fail++; $display("FAIL rand_rdata c%0d: rdata=%h want %h", k, rdata1, model_rdata);
      end
      if (e_en) begin
        n_chk++;
        if (maddr1 !== exp_addr || mwe1 !== exp_we || (exp_we && mwd1 !== exp_wd)) begin
          n_fail++; $display("FAIL rand_port c%0d: addr=%h we=%b wdata=%h want %h %b %h", k, maddr1, mwe1, mwd1, exp_addr, exp_we, exp_wd);
        end
      end
      if (pend && k == done_c) pend = 0;
      if_req   = ($urandom_range(0, 1) == 1);
      ls_req   = ($urandom_range(0, 1) == 1);
      ls_we    = ($urandom_range(0, 1) == 1);
      if_addr  = 16'($urandom_range(0, 31));
      ls_addr  = 16'($urandom_range(0, 31));
      ls_wdata = 16'($urandom);
      if (!pend && (if_req || ls_req)) begin
`ifdef MEM_ARB_RR_EN
        win_ls = ls_req && (!if_req || !ptr);
        ptr    = win_ls;
`else
        win_ls = ls_req;
`endif
        pend = 1; grant_c = k; done_c = k + 3; own_ls = win_ls;
        exp_addr = win_ls ? ls_addr : if_addr;
        exp_we   = win_ls && ls_we;
        exp_wd   = ls_wdata;
        rd       = !exp_we;
        if (exp_we) ref_mem[exp_addr] = ls_wdata;
        else        exp_data = ref_mem[exp_addr];
      end
      tick();
    end
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_conflict();
    test_mem_lat4();
    test_reset_wait();
    test_dropped();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
